// File: rtl/bkm_pkg.sv
// bkm_pkg: shared constants, FSM encoding and counter-width helper for the BKM z-accumulator
//   Contents: W_DEF/N_DEF default widths, ST_IDLE/ST_RUN/ST_DONE state codes, iter_width()
package bkm_pkg;
    localparam int W_DEF = 64;
    localparam int N_DEF = 64;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    // smallest width whose range holds 0..n, i.e. 2^width > n
    function automatic int iter_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/bkm_ashr.sv
// bkm_ashr: W-bit barrel arithmetic right shift by an NW-bit amount, optional half-up rounding
//   Ports: i_val (W, two's complement operand), i_amt (NW, shift amount), o_val (W, shifted result)
//   Macro BKM_ZACC_ROUND_EN: when defined, adds 2^(amt-1) before shifting for 1 <= amt <= W
module bkm_ashr #(
    parameter int W  = 64,
    parameter int NW = 7
) (
    input  logic [W-1:0]  i_val,
    input  logic [NW-1:0] i_amt,
    output logic [W-1:0]  o_val
);
    // one guard bit so the rounding add cannot overflow and amt == W stays in the barrel
    localparam int D = W + 1;
    localparam int S = $clog2(D);
    logic [D-1:0] w_rnd;
    logic [D-1:0] w_sum;
    logic [D-1:0] w_stg [0:S];
    logic [S-1:0] w_amt;
    logic         w_big;
`ifdef BKM_ZACC_ROUND_EN
    assign w_rnd = (i_amt != '0 && 32'(i_amt) <= W) ? D'(1) << (i_amt - 1'b1) : '0;
`else
    assign w_rnd = '0;
`endif
    assign w_sum    = {i_val[W-1], i_val} + w_rnd;
    // past W every bit is shifted out, leaving only sign fill
    assign w_big    = 32'(i_amt) > W;
    assign w_amt    = w_big ? '0 : S'(i_amt);
    assign w_stg[0] = w_sum;
    for (genvar i = 0; i < S; i++) begin : g_stg
        assign w_stg[i+1] = w_amt[i] ? D'($signed(w_stg[i]) >>> (2 ** i)) : w_stg[i];
    end
    assign o_val = w_big ? {W{w_sum[D-1]}} : w_stg[S][W-1:0];
endmodule

// File: rtl/bkm_z_accumulator.sv
// bkm_z_accumulator: iterative z = x + jy register of the BKM E-mode datapath
//   Inputs : clk, arst (async, active-high), start, x0/y0 (initial z), d_valid, p_x/p_y (d*z)
//   Outputs: z_x/z_y (current z), iter (index n), busy (RUN), done (1-cycle pulse), x_res/y_res
//   Each accepted digit: z <= z + ashr(p, n). Macro BKM_ZACC_ROUND_EN selects rounding shifts.
module bkm_z_accumulator
    import bkm_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int N  = N_DEF,
    parameter int NW = iter_width(N)
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          start,
    input  logic [W-1:0]  x0,
    input  logic [W-1:0]  y0,
    input  logic          d_valid,
    input  logic [W-1:0]  p_x,
    input  logic [W-1:0]  p_y,
    output logic [W-1:0]  z_x,
    output logic [W-1:0]  z_y,
    output logic [NW-1:0] iter,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  x_res,
    output logic [W-1:0]  y_res
);
    logic [1:0]    r_state;
    logic [W-1:0]  r_zx, r_zy, r_xres, r_yres;
    logic [NW-1:0] r_iter;
    logic [W-1:0]  w_sx, w_sy, w_nx, w_ny;
    logic          w_acc, w_last;
    bkm_ashr #(.W(W), .NW(NW)) u_ashr_x (.i_val(p_x), .i_amt(r_iter), .o_val(w_sx));
    bkm_ashr #(.W(W), .NW(NW)) u_ashr_y (.i_val(p_y), .i_amt(r_iter), .o_val(w_sy));
    // modulo-2^W wrap is intentional: no saturation, no overflow flag
    assign w_nx   = r_zx + w_sx;
    assign w_ny   = r_zy + w_sy;
    assign w_acc  = r_state == ST_RUN && d_valid;
    assign w_last = r_iter == NW'(N - 1);
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= ST_IDLE;
            r_zx    <= '0;
            r_zy    <= '0;
            r_iter  <= '0;
            r_xres  <= '0;
            r_yres  <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_state <= ST_RUN;
            r_zx    <= x0;
            r_zy    <= y0;
            r_iter  <= '0;
        end else if (w_acc) begin
            r_zx   <= w_nx;
            r_zy   <= w_ny;
            r_iter <= r_iter + 1'b1;
            if (w_last) begin
                r_xres  <= w_nx;
                r_yres  <= w_ny;
                r_state <= ST_DONE;
            end
        end else if (r_state == ST_DONE) begin
            r_state <= ST_IDLE;
        end
    end
    assign z_x   = r_zx;
    assign z_y   = r_zy;
    assign iter  = r_iter;
    assign busy  = r_state == ST_RUN;
    assign done  = r_state == ST_DONE;
    assign x_res = r_xres;
    assign y_res = r_yres;
endmodule

// File: tb/tb_bkm_z_accumulator.sv
// tb_bkm_z_accumulator: scoreboard bench for bkm_z_accumulator (W=16, N=4 and N=20 instances)
module tb_bkm_z_accumulator;
`ifdef BKM_ZACC_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif
    logic clk = 1'b0;
    logic arst = 1'b0;
    always #5 clk = ~clk;

    logic        a_start = 1'b0, a_dv = 1'b0;
    logic [15:0] a_x0 = '0, a_y0 = '0, a_px = '0, a_py = '0;
    logic [15:0] a_zx, a_zy, a_xres, a_yres;
    logic [2:0]  a_iter;
    logic        a_busy, a_done;

    logic        b_start = 1'b0, b_dv = 1'b0;
    logic [15:0] b_x0 = '0, b_y0 = '0, b_px = '0, b_py = '0;
    logic [15:0] b_zx, b_zy, b_xres, b_yres;
    logic [4:0]  b_iter;
    logic        b_busy, b_done;

    int tests = 0;
    int failed = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    bkm_z_accumulator #(.W(16), .N(4), .NW(3)) u_a (
        .clk(clk), .arst(arst), .start(a_start), .x0(a_x0), .y0(a_y0), .d_valid(a_dv),
        .p_x(a_px), .p_y(a_py), .z_x(a_zx), .z_y(a_zy), .iter(a_iter), .busy(a_busy),
        .done(a_done), .x_res(a_xres), .y_res(a_yres));

    bkm_z_accumulator #(.W(16), .N(20), .NW(5)) u_b (
        .clk(clk), .arst(arst), .start(b_start), .x0(b_x0), .y0(b_y0), .d_valid(b_dv),
        .p_x(b_px), .p_y(b_py), .z_x(b_zx), .z_y(b_zy), .iter(b_iter), .busy(b_busy),
        .done(b_done), .x_res(b_xres), .y_res(b_yres));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step_a(input logic v, input logic [15:0] px, input logic [15:0] py);
        a_dv = v;
        a_px = px;
        a_py = py;
        @(negedge clk);
        a_dv = 1'b0;
    endtask

    task automatic start_a(input logic [15:0] x, input logic [15:0] y);
        a_start = 1'b1;
        a_x0 = x;
        a_y0 = y;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic step_b(input logic v, input logic [15:0] px, input logic [15:0] py);
        b_dv = v;
        b_px = px;
        b_py = py;
        @(negedge clk);
        b_dv = 1'b0;
    endtask

    // monitors: pop the expected result whenever a done pulse is presented
    always @(posedge clk) begin
        #1;
        if (a_done) begin
            if (qa.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL a_unexpected_done: got x_res %h y_res %h expected no done", a_xres, a_yres);
            end else chk("a_result", {a_xres, a_yres}, qa.pop_front());
        end
    end

    always @(posedge clk) begin
        #1;
        if (b_done) begin
            if (qb.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL b_unexpected_done: got x_res %h y_res %h expected no done", b_xres, b_yres);
            end else chk("b_result", {b_xres, b_yres}, qb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] px, py;
        arst = 1'b1;
        #1;
        chk("rst_zx", a_zx, 0);
        chk("rst_iter", a_iter, 0);
        chk("rst_busy_done", {a_busy, a_done}, 0);
        chk("rst_res", {a_xres, a_yres}, 0);
        @(negedge clk);
        arst = 1'b0;

        // iteration sum, back-to-back digits
        qa.push_back({16'h02E0, 16'hFFF2});
        start_a(16'h0100, 16'h0010);
        chk("t1_busy", a_busy, 1);
        chk("t1_iter0", a_iter, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk("t1_no_early_done", a_done, 0);
            step_a(1'b1, 16'h0100, 16'hFFF0);
        end
        chk("t1_done_rise", a_done, 1);
        chk("t1_zx", a_zx, 16'h02E0);
        step_a(1'b0, 16'h0, 16'h0);
        chk("t1_done_fall", a_done, 0);
        chk("t1_idle", a_busy, 0);
        chk("t1_res_hold", a_xres, 16'h02E0);

        // stall after the first digit
        qa.push_back({16'h02E0, 16'hFFF2});
        start_a(16'h0100, 16'h0010);
        step_a(1'b1, 16'h0100, 16'hFFF0);
        for (int i = 0; i < 3; i++) begin
            step_a(1'b0, 16'hAAAA, 16'h5555);
            chk("t2_iter_hold", a_iter, 1);
            chk("t2_z_hold", {a_zx, a_zy}, {16'h0200, 16'h0000});
        end
        for (int i = 0; i < 3; i++) step_a(1'b1, 16'h0100, 16'hFFF0);
        step_a(1'b0, 16'h0, 16'h0);

        // rounding at iter 1
        qa.push_back(RND ? {16'h0002, 16'hFFFF} : {16'h0001, 16'hFFFE});
        start_a(16'h0, 16'h0);
        step_a(1'b1, 16'h0, 16'h0);
        step_a(1'b1, 16'h0003, 16'hFFFD);
        chk("t4_round", {a_zx, a_zy}, RND ? {16'h0002, 16'hFFFF} : {16'h0001, 16'hFFFE});
        step_a(1'b1, 16'h0, 16'h0);
        step_a(1'b1, 16'h0, 16'h0);
        step_a(1'b0, 16'h0, 16'h0);

        // wrap modulo 2^16
        qa.push_back({16'h8000, 16'h0000});
        start_a(16'h7FFF, 16'h0);
        step_a(1'b1, 16'h0001, 16'h0);
        chk("t5_wrap", a_zx, 16'h8000);
        chk("t5_no_stall", {a_busy, a_iter}, {1'b1, 3'd1});
        for (int i = 0; i < 3; i++) step_a(1'b1, 16'h0, 16'h0);
        step_a(1'b0, 16'h0, 16'h0);

        // async reset mid-operation, no done expected
        start_a(16'h0100, 16'h0);
        step_a(1'b1, 16'h0100, 16'h0);
        step_a(1'b1, 16'h0100, 16'h0);
        chk("t6_iter2", a_iter, 2);
        #2 arst = 1'b1;
        #1;
        chk("t6_rst_z", {a_zx, a_zy}, 0);
        chk("t6_rst_iter", a_iter, 0);
        chk("t6_rst_flags", {a_busy, a_done}, 0);
        chk("t6_rst_res", {a_xres, a_yres}, 0);
        #1 arst = 1'b0;
        @(negedge clk);
        step_a(1'b0, 16'h0, 16'h0);
        chk("t6_stay_idle", {a_busy, a_done}, 0);

        // start while busy is ignored; fresh run completes
        qa.push_back({16'h0080, 16'h0000});
        start_a(16'h0040, 16'h0);
        step_a(1'b1, 16'h0040, 16'h0);
        a_start = 1'b1;
        a_x0 = 16'h1234;
        step_a(1'b0, 16'h0, 16'h0);
        a_start = 1'b0;
        chk("t6_start_ignored", {a_zx, 13'd0, a_iter}, {16'h0080, 13'd0, 3'd1});
        for (int i = 0; i < 3; i++) step_a(1'b1, 16'h0, 16'h0);
        step_a(1'b0, 16'h0, 16'h0);

        // large shifts, N=20
        qb.push_back(RND ? {16'hFFFE, 16'h0002} : {16'hFFFD, 16'h0001});
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            px = (i == 16 || i == 17 || i == 19) ? 16'h8000 : (i == 18 ? 16'h7FFF : 16'h0000);
            py = (i == 14) ? 16'h6000 : 16'h0000;
            step_b(1'b1, px, py);
            if (i == 16) chk("t3_iter16", b_zx, RND ? 16'h0000 : 16'hFFFF);
            if (i == 18) chk("t3_iter18", b_zx, RND ? 16'hFFFF : 16'hFFFE);
        end
        chk("t3_done", b_done, 1);
        step_b(1'b0, 16'h0, 16'h0);

        repeat (3) @(negedge clk);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
